// File: rtl/tx_scheduler.sv
// Two-requester transmit scheduler: round-robin arbitration, one packet at a time
// to the encoder, timeout abort in SEND and a fixed idle gap between packets.
module tx_scheduler #(
    parameter int PACKET_SIZE = 16,
    parameter int GAP_CYCLES  = 8,
    parameter int TIMEOUT     = 4096
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [1:0]             req,
    input  logic [PACKET_SIZE-1:0] data0,
    input  logic [PACKET_SIZE-1:0] data1,
    output logic [1:0]             ack,
    output logic [1:0]             complete,
    output logic                   error,
    output logic                   busy,
    output logic [PACKET_SIZE-1:0] enc_data,
    output logic                   enc_reset,
    output logic                   enc_enable,
    input  logic                   enc_done
);

    localparam int SEND_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                winner_q;
    logic                last_q;
    logic [SEND_W-1:0]   send_cnt_q;
    logic [GAP_W-1:0]    gap_cnt_q;
    logic [1:0]          ack_q, complete_q;
    logic                error_q;

    logic                grant;
    logic                grant_idx;
    logic [1:0]          ack_d, complete_d;
    logic                error_d;

    always_comb begin
        state_d    = state_q;
        grant      = 1'b0;
        grant_idx  = 1'b0;
        ack_d      = 2'b00;
        complete_d = 2'b00;
        error_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    grant = 1'b1;
                    if (req == 2'b01)
                        grant_idx = 1'b0;
                    else if (req == 2'b10)
                        grant_idx = 1'b1;
                    else
                        grant_idx = ~last_q;
                    ack_d   = 2'b01 << grant_idx;
                    state_d = SEND;
                end
            end
            SEND: begin
                // Completion wins over a timeout that lands on the same cycle.
                if (enc_done) begin
                    state_d    = GAP;
                    complete_d = 2'b01 << winner_q;
                end else if (send_cnt_q == SEND_W'(TIMEOUT - 1)) begin
                    state_d = GAP;
                    error_d = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            winner_q   <= 1'b0;
            last_q     <= 1'b1;
            send_cnt_q <= '0;
            gap_cnt_q  <= '0;
            ack_q      <= 2'b00;
            complete_q <= 2'b00;
            error_q    <= 1'b0;
            enc_data   <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            complete_q <= complete_d;
            error_q    <= error_d;
            if (grant) begin
                winner_q <= grant_idx;
                last_q   <= grant_idx;
                enc_data <= grant_idx ? data1 : data0;
            end
            // Counters only run while their state persists, so they never wrap.
            send_cnt_q <= (state_q == SEND && state_d == SEND) ? send_cnt_q + 1'b1 : '0;
            gap_cnt_q  <= (state_q == GAP && state_d == GAP) ? gap_cnt_q + 1'b1 : '0;
        end
    end

    assign ack        = ack_q;
    assign complete   = complete_q;
    assign error      = error_q;
    assign enc_enable = (state_q == SEND);
    assign enc_reset  = (state_q != SEND);
    assign busy       = (state_q != IDLE);

endmodule

// File: doc/tx_scheduler.md
TX_SCHEDULER -- requirements
Module: tx_scheduler

Interface
REQ-001 Parameter: PACKET_SIZE, 16, width of each requester's packet and of enc_data.
REQ-002 Parameter: GAP_CYCLES, 8, inter-packet idle cycles with the encoder disabled; legal range >= 1.
REQ-003 Parameter: TIMEOUT, 4096, maximum SEND cycles before abort; legal range >= 2.
REQ-004 Port: clock  input  1  system clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: req  input  2  per-requester level request; bit i = requester i.
REQ-007 Port: data0, data1  input  PACKET_SIZE each  packet of requester 0 / 1; held stable while req[i]=1.
REQ-008 Port: ack  output  2  one-cycle pulse; bit i high = packet of requester i captured.
REQ-009 Port: complete  output  2  one-cycle pulse; bit i high = requester i's packet fully transmitted.
REQ-010 Port: error  output  1  one-cycle pulse on SEND timeout abort.
REQ-011 Port: busy  output  1  high in any state other than IDLE.
REQ-012 Port: enc_data  output  PACKET_SIZE  captured packet to the encoder; changes only at capture.
REQ-013 Port: enc_reset  output  1  active-high synchronous reset to the encoder.
REQ-014 Port: enc_enable  output  1  encoder output enable.
REQ-015 Port: enc_done  input  1  encoder completion flag (sticky until enc_reset).

Function
REQ-016 States SHALL be IDLE, SEND, GAP, held in a registered state variable.
REQ-017 enc_enable SHALL be 1 exactly when state=SEND; enc_reset SHALL be 1 exactly when state!=SEND.
REQ-018 busy SHALL be 1 exactly when state!=IDLE.
REQ-019 IDLE, req=00: stay in IDLE.
REQ-020 IDLE, exactly one req bit set: grant that requester.
REQ-021 IDLE, req=11: grant the requester not served last (round-robin pointer).
REQ-022 On grant, at the same edge: capture the winner's data into enc_data, set ack[winner] for the following cycle only, record the winner, enter SEND, clear the SEND cycle counter.
REQ-023 A req bit dropped before its ack SHALL be treated as withdrawn, with no ack and no pointer update.
REQ-024 Round-robin pointer SHALL update only on grant, to the granted index.
REQ-025 SEND, enc_done=1 sampled: enter GAP and pulse complete[recorded winner] for exactly one cycle.
REQ-026 enc_done SHALL be ignored in all states other than SEND.
REQ-027 SEND counter SHALL increment each SEND cycle.
REQ-028 If the counter reaches TIMEOUT-1 with enc_done=0: enter GAP and pulse error for one cycle; no complete pulse.
REQ-029 If enc_done=1 on the timeout cycle, completion SHALL take precedence: complete pulses, error stays 0.
REQ-030 GAP SHALL last exactly GAP_CYCLES cycles, then enter IDLE.
REQ-031 Requests during SEND or GAP SHALL remain pending and be arbitrated only in IDLE.
REQ-032 At most one ack bit and one complete bit SHALL be high in any cycle.
REQ-033 Counters SHALL be sized to hold TIMEOUT-1 and GAP_CYCLES without wrap.

Reset
REQ-034 While reset=0, the following SHALL hold immediately (asynchronous, no clock required): state=IDLE, ack=00, complete=00, error=0, busy=0, enc_enable=0, enc_reset=1, enc_data=0, counters=0, round-robin pointer favouring requester 0 on the first tie.
REQ-035 reset asserted mid-SEND SHALL abort at once: enc_enable=0, enc_reset=1, no complete or error pulse, and the packet is discarded.
REQ-036 After reset deassertion, the first rising edge SHALL evaluate IDLE arbitration normally.

Verification
REQ-037 Single packet, with PACKET_SIZE=8, encoder LOW interval 2 (3 edges/bit), data0=8'h00, req=01 -> ack=01 for one cycle; complete=01 exactly 26 cycles after ack rises; busy falls 26+GAP_CYCLES cycles after ack.
REQ-038 Contention: req=11 held continuously from reset -> grant order 0,1,0,1; each ack is followed by its own complete before the next ack.
REQ-039 Timeout: TIMEOUT=10, enc_done tied 0 -> SEND lasts 10 cycles, error pulses once, no complete, then GAP and IDLE.
REQ-040 Withdraw: req[1] pulsed high for 1 cycle during SEND of requester 0 -> ack[1] never asserts.
REQ-041 Reset mid-SEND: reset=0 at SEND cycle 5 -> same cycle enc_enable=0, enc_reset=1, busy=0; after release, req=01 restarts with fresh ack.
REQ-042 Stale done: enc_done forced 1 during IDLE and GAP -> no complete pulse until a SEND cycle samples enc_done=1.
